// File: rtl/mod_exp_engine.sv
// mod_exp_engine: right-to-left square-and-multiply base^exp mod m.
// Define MOD_EXP_CONST_TIME_EN for fixed EXPW-iteration timing.
module mod_exp_engine #(
  parameter int W    = 64,
  parameter int EXPW = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [W-1:0]    base,
  input  logic            base_sign,
  input  logic [EXPW-1:0] exponent,
  input  logic [W-1:0]    modulus,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    result,
  output logic            mul_enable,
  output logic [W-1:0]    mul_a,
  output logic [W-1:0]    mul_b,
  input  logic            mul_done,
  input  logic [2*W-1:0]  mul_result,
  output logic            red_enable,
  output logic [2*W-1:0]  red_input,
  output logic [W-1:0]    red_modulus,
  input  logic            red_done,
  input  logic [W-1:0]    red_result
);

  typedef enum logic [2:0] {
    IDLE, PREP, MUL, RED_M, SQR, RED_S, DONE
  } state_t;

  state_t state, state_d;
  state_t prep_nx, rs_nx;

  logic            first;
  logic            sign_r;
  logic            last_m;
  logic [W-1:0]    mod_r;
  logic [W-1:0]    acc;
  logic [W-1:0]    acc_nx;
  logic [W-1:0]    b;
  logic [W-1:0]    t_abs;
  logic [EXPW-1:0] e;
  logic [EXPW-1:0] e_sh;
  logic [2*W-1:0]  prod;

`ifdef MOD_EXP_CONST_TIME_EN
  localparam int CW = $clog2(EXPW + 1);
  logic [CW-1:0] cnt;
`endif

  always_comb begin
    e_sh   = e >> 1;
    acc_nx = (state == RED_M && red_done && e[0]) ?
             red_result : acc;
`ifdef MOD_EXP_CONST_TIME_EN
    last_m  = (cnt == CW'(EXPW - 1));
    prep_nx = MUL;
    rs_nx   = MUL;
`else
    // the final squaring is skipped once no exponent bits remain
    last_m  = (e_sh == '0);
    prep_nx = (e == '0) ? DONE : (e[0] ? MUL : SQR);
    rs_nx   = e_sh[0] ? MUL :
              (((e_sh >> 1) == '0) ? DONE : SQR);
`endif
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = PREP;
      PREP:    if (red_done) state_d = prep_nx;
      MUL:     if (mul_done) state_d = RED_M;
      RED_M:   if (red_done) state_d = last_m ? DONE : SQR;
      SQR:     if (mul_done) state_d = RED_S;
      RED_S:   if (red_done) state_d = rs_nx;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mul_a     = '0;
    mul_b     = '0;
    red_input = '0;
    unique case (1'b1)
      state == MUL: begin
        mul_a = acc;
        mul_b = b;
      end
      state == SQR: begin
        mul_a = b;
        mul_b = b;
      end
      state == PREP: red_input = {{W{1'b0}}, t_abs};
      state == RED_M,
      state == RED_S: red_input = prod;
      default: ;
    endcase
  end

  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);
  assign mul_enable  = first && (state == MUL || state == SQR);
  assign red_enable  = first &&
                       (state inside {PREP, RED_M, RED_S});
  assign red_modulus = mod_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      first  <= 1'b0;
      sign_r <= 1'b0;
      mod_r  <= '0;
      acc    <= '0;
      b      <= '0;
      t_abs  <= '0;
      e      <= '0;
      prod   <= '0;
      result <= '0;
`ifdef MOD_EXP_CONST_TIME_EN
      cnt    <= '0;
`endif
    end else begin
      state <= state_d;
      first <= (state_d != state);
      if (state_d == DONE && state != DONE)
        result <= (mod_r == W'(1)) ? '0 : acc_nx;
      unique case (state)
        IDLE: if (start) begin
          mod_r  <= modulus;
          e      <= exponent;
          acc    <= W'(1);
          sign_r <= base_sign;
          t_abs  <= base_sign ? -base : base;
`ifdef MOD_EXP_CONST_TIME_EN
          cnt    <= '0;
`endif
        end
        PREP: if (red_done)
          b <= (sign_r && red_result != '0) ?
               mod_r - red_result : red_result;
        // product is latched so red_input holds while the
        // shared multiplier moves on
        MUL, SQR: if (mul_done) prod <= mul_result;
        RED_M: if (red_done) acc <= acc_nx;
        RED_S: if (red_done) begin
          b <= red_result;
          e <= e_sh;
`ifdef MOD_EXP_CONST_TIME_EN
          cnt <= cnt + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
